// File: rtl/mcpu_key_fifo.sv
// Keyboard event queue: edge-detects keycode presses (and optionally releases) into a small FIFO read by the CPU.
// Latency: event pushed at the edge after the keycode change, visible on key_out one edge later; pop likewise.
// Backpressure: none upstream; a push into a full FIFO without a same-edge pop is dropped and sets sticky overflow.
module mcpu_key_fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 3,
    parameter int RELEASE_EV = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            keycode,
    input  logic                  pop,
    input  logic                  clr_ovf,
    output logic [DATA_WIDTH-1:0] key_out,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [7:0]            kc_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0] key_out_q, key_out_d;
    logic [7:0]            mem_q [DEPTH];

    logic       press, release_ev, push;
    logic [7:0] push_dat;
    logic       empty_w, full_w, do_push, do_pop;

    // Event detection, FIFO bookkeeping and next key_out word.
    always_comb begin
        press      = keycode[7] && (keycode != kc_q);
        release_ev = (RELEASE_EV != 0) && kc_q[7] && !keycode[7];
        push       = press || release_ev;
        push_dat   = press ? keycode : {1'b0, kc_q[6:0]};

        empty_w = (count_q == '0);
        full_w  = (count_q == COUNT_FULL);
        // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
        do_push = push && (!full_w || pop);
        do_pop  = pop && !empty_w;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;

        // Setting the sticky flag takes priority over clearing it.
        ovf_d = ovf_q;
        if (push && full_w && !pop) ovf_d = 1'b1;
        else if (clr_ovf)           ovf_d = 1'b0;

        key_out_d = '0;
        key_out_d[DATA_WIDTH-2] = ovf_q;
        if (!empty_w) begin
            key_out_d[DATA_WIDTH-1] = 1'b1;
            key_out_d[7:0]          = mem_q[rd_ptr_q];
        end
    end

    // Control state; reset discards queued entries and the last keycode sample.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kc_q      <= 8'h00;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            key_out_q <= '0;
        end else begin
            kc_q      <= keycode;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            key_out_q <= key_out_d;
        end
    end

    // Entry storage; contents are only exposed while count is non-zero, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

    assign key_out  = key_out_q;
    assign count    = count_q;
    assign empty    = (count_q == '0);
    assign full     = (count_q == COUNT_FULL);
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mcpu_key_fifo.sv
// Directed bench for mcpu_key_fifo: expected head bytes are queued by the stimulus,
// a negedge monitor checks key_out against them whenever a pop is presented on a valid head.
// Status outputs are checked directly against hand-computed constants.
module tb_mcpu_key_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  keycode;
    logic        pop;
    logic        clr_ovf;

    logic [15:0] key_out;
    logic [3:0]  count;
    logic        empty, full, overflow;

    logic [15:0] r_key_out;
    logic [3:0]  r_count;
    logic        r_empty, r_full, r_overflow;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_main [$];
    logic [7:0] exp_rel  [$];
    logic       rel_en = 1'b0;
    logic [7:0] e_main, e_rel;

    always #5 clk = ~clk;

    mcpu_key_fifo #(.DATA_WIDTH(16), .DEPTH_LOG2(3), .RELEASE_EV(0)) dut (
        .clk(clk), .reset(reset), .keycode(keycode), .pop(pop), .clr_ovf(clr_ovf),
        .key_out(key_out), .count(count), .empty(empty), .full(full), .overflow(overflow)
    );

    mcpu_key_fifo #(.DATA_WIDTH(16), .DEPTH_LOG2(3), .RELEASE_EV(1)) dut_rel (
        .clk(clk), .reset(reset), .keycode(keycode), .pop(pop), .clr_ovf(clr_ovf),
        .key_out(r_key_out), .count(r_count), .empty(r_empty), .full(r_full), .overflow(r_overflow)
    );

    // Scoreboard monitor: a pop on a valid head must consume the oldest expected entry.
    always @(negedge clk) begin
        if (reset && pop && key_out[15]) begin
            tests++;
            if (exp_main.size() == 0) begin
                fails++;
                $display("FAIL main_head: got %02h, required no entry", key_out[7:0]);
            end else begin
                e_main = exp_main.pop_front();
                if (key_out[7:0] !== e_main) begin
                    fails++;
                    $display("FAIL main_head: got %02h, required %02h", key_out[7:0], e_main);
                end
            end
        end
        if (rel_en && reset && pop && r_key_out[15]) begin
            tests++;
            if (exp_rel.size() == 0) begin
                fails++;
                $display("FAIL rel_head: got %02h, required no entry", r_key_out[7:0]);
            end else begin
                e_rel = exp_rel.pop_front();
                if (r_key_out[7:0] !== e_rel) begin
                    fails++;
                    $display("FAIL rel_head: got %02h, required %02h", r_key_out[7:0], e_rel);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
        tests++;
        if (got !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Change keycode, let the push edge pass, then one more edge so key_out is current.
    task automatic set_kc(input logic [7:0] v);
        keycode = v;
        step(2);
    endtask

    task automatic do_pop();
        pop = 1'b1;
        step(1);
        pop = 1'b0;
        step(1);
    endtask

    initial begin
        reset   = 1'b0;
        keycode = 8'h81;
        pop     = 1'b0;
        clr_ovf = 1'b0;
        step(3);

        // 1: reset state, then a key held across reset release gives exactly one event
        chk("rst_key_out", key_out, 16'h0000);
        chk("rst_empty", {15'd0, empty}, 16'd1);
        chk("rst_count", {12'd0, count}, 16'd0);
        chk("rst_full", {15'd0, full}, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        exp_main.push_back(8'h81);
        step(3);
        chk("t1_count", {12'd0, count}, 16'd1);
        chk("t1_key_out", key_out, 16'h8081);
        do_pop();
        step(1);
        chk("t1_empty", {15'd0, empty}, 16'd1);
        chk("t1_key_out_idle", key_out, 16'h0000);

        // 2: press/release sequence; release variant also queues the release
        rel_en = 1'b1;
        set_kc(8'h85); exp_main.push_back(8'h85); exp_rel.push_back(8'h85);
        set_kc(8'h00);                             exp_rel.push_back(8'h05);
        set_kc(8'h86); exp_main.push_back(8'h86); exp_rel.push_back(8'h86);
        chk("t2_count", {12'd0, count}, 16'd2);
        chk("t2_rel_count", {12'd0, r_count}, 16'd3);
        do_pop();
        do_pop();
        do_pop();
        chk("t2_empty", {15'd0, empty}, 16'd1);
        chk("t2_key_out_idle", key_out, 16'h0000);
        chk("t2_rel_empty", {15'd0, r_empty}, 16'd1);
        chk("t2_rel_left", 16'(exp_rel.size()), 16'd0);
        rel_en = 1'b0;

        // 3: nine presses into eight slots, ninth dropped
        for (int i = 1; i <= 9; i++) begin
            set_kc(8'h90 + 8'(i));
            if (i <= 8) exp_main.push_back(8'h90 + 8'(i));
        end
        chk("t3_full", {15'd0, full}, 16'd1);
        chk("t3_count", {12'd0, count}, 16'd8);
        chk("t3_overflow", {15'd0, overflow}, 16'd1);
        chk("t3_key_out", key_out, 16'hC091);

        // 6a: clear on the same edge as a dropped push loses to the set
        keycode = 8'hB0; clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        step(1);
        chk("t6_ovf_set_wins", {15'd0, overflow}, 16'd1);
        chk("t6_count_after_drop", {12'd0, count}, 16'd8);
        // 6b: clear alone
        clr_ovf = 1'b1;
        step(1);
        clr_ovf = 1'b0;
        step(1);
        chk("t6_ovf_cleared", {15'd0, overflow}, 16'd0);
        chk("t6_key_out", key_out, 16'h8091);

        // 4: full FIFO, push and pop on the same edge
        keycode = 8'hA0; pop = 1'b1;
        exp_main.push_back(8'hA0);
        step(1);
        pop = 1'b0;
        step(1);
        chk("t4_count", {12'd0, count}, 16'd8);
        chk("t4_overflow", {15'd0, overflow}, 16'd0);
        chk("t4_full", {15'd0, full}, 16'd1);
        chk("t4_head", key_out, 16'h8092);
        for (int i = 0; i < 8; i++) do_pop();
        chk("t4_drained", {12'd0, count}, 16'd0);
        chk("t4_sb_left", 16'(exp_main.size()), 16'd0);

        // 5: empty FIFO, push and pop on the same edge keeps the entry
        keycode = 8'hC1; pop = 1'b1;
        exp_main.push_back(8'hC1);
        step(1);
        pop = 1'b0;
        step(1);
        chk("t5_count", {12'd0, count}, 16'd1);
        chk("t5_key_out", key_out, 16'h80C1);
        do_pop();
        pop = 1'b1;
        step(1);
        pop = 1'b0;
        step(1);
        chk("t5_empty_pop_count", {12'd0, count}, 16'd0);
        chk("t5_empty_pop_empty", {15'd0, empty}, 16'd1);
        chk("t5_empty_pop_key_out", key_out, 16'h0000);

        // 6c: reset mid-stream discards entries without waiting for a clock
        set_kc(8'hD1);
        set_kc(8'hD2);
        chk("t6_pre_reset_count", {12'd0, count}, 16'd2);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_reset_count", {12'd0, count}, 16'd0);
        chk("t6_reset_empty", {15'd0, empty}, 16'd1);
        chk("t6_reset_key_out", key_out, 16'h0000);
        exp_main.delete();
        step(2);
        reset = 1'b1;
        step(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
